// File: rtl/inst_fetch_pkg.sv
// Shared constants, FSM state encoding and PC helper for the fetch stage.
package inst_fetch_pkg;

    localparam int          REG_BUS   = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        TRUE_V    = 1'b1;
    localparam logic        FALSE_V   = 1'b0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_HOLD = 2'd3
    } if_state_t;

    // Sequential PC step; wraps modulo 2^32 and does not check alignment.
    function automatic logic [REG_BUS-1:0] pc_inc(input logic [REG_BUS-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter with pending branch/jump redirect.
// pc always points at the instruction after the one on the decoder output,
// so a redirect is only applied once the delay slot has been delivered.
module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [REG_BUS-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               deliver,
    input  logic               capture,
    input  logic [REG_BUS-1:0] br_addr,
    output logic [REG_BUS-1:0] pc
);

    logic               redir_pend;
    logic [REG_BUS-1:0] redir_tgt;
    logic [REG_BUS-1:0] pc_next;

    // Next PC: a capture in the same edge as a delivery means the delivered word
    // is the delay slot, so the fresh target takes effect immediately.
    always_comb begin
        pc_next = pc;
        if (deliver) begin
            if (capture) begin
                pc_next = br_addr;
            end else if (redir_pend) begin
                pc_next = redir_tgt;
            end else begin
                pc_next = pc_inc(pc);
            end
        end
    end

    // PC and redirect bookkeeping; repeated captures simply rewrite the same target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            redir_pend <= FALSE_V;
            redir_tgt  <= ZERO_WORD;
        end else begin
            pc <= pc_next;
            if (deliver) begin
                redir_pend <= FALSE_V;
            end else if (capture) begin
                redir_pend <= TRUE_V;
                redir_tgt  <= br_addr;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding request, 1-entry stall buffer and
// registered decoder outputs.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IF_IDLE | reset state, no request
//   IF_REQ  | request valid, waiting for grant
//   IF_WAIT | one request outstanding, waiting for rvalid
//   IF_HOLD | returned word buffered while decoder stalls
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [REG_BUS-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               br_e_i,
    input  logic [REG_BUS-1:0] br_addr_i,
    output logic               inst_sram_req_o,
    output logic [REG_BUS-1:0] inst_sram_addr_o,
    input  logic               inst_sram_gnt_i,
    input  logic               inst_sram_rvalid_i,
    input  logic [REG_BUS-1:0] inst_sram_rdata_i,
    output logic [REG_BUS-1:0] inst_o,
    output logic [REG_BUS-1:0] inst_addr_o,
    output logic               inst_valid_o
);

    if_state_t          state;
    if_state_t          state_next;
    logic [REG_BUS-1:0] pc;
    logic [REG_BUS-1:0] hold_buf;
    logic [REG_BUS-1:0] deliver_word;
    logic               deliver;
    logic               buffer_en;
    logic               capture;

    // A redirect only counts while a real instruction sits on the output.
    assign capture          = br_e_i & inst_valid_o;
    assign inst_sram_addr_o = pc;

    inst_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .deliver (deliver),
        .capture (capture),
        .br_addr (br_addr_i),
        .pc      (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request strobe and delivery/buffer decisions.
    always_comb begin
        state_next      = state;
        inst_sram_req_o = FALSE_V;
        deliver         = FALSE_V;
        buffer_en       = FALSE_V;
        deliver_word    = inst_sram_rdata_i;
        case (state)
            IF_IDLE: begin
                state_next = IF_REQ;
            end
            IF_REQ: begin
                inst_sram_req_o = TRUE_V;
                if (inst_sram_gnt_i) begin
                    state_next = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (inst_sram_rvalid_i) begin
                    if (stall_i) begin
                        buffer_en  = TRUE_V;
                        state_next = IF_HOLD;
                    end else begin
                        deliver    = TRUE_V;
                        state_next = IF_REQ;
                    end
                end
            end
            IF_HOLD: begin
                deliver_word = hold_buf;
                if (!stall_i) begin
                    deliver    = TRUE_V;
                    state_next = IF_REQ;
                end
            end
            default: begin
                state_next = IF_IDLE;
            end
        endcase
    end

    // Hold buffer captures a returned word the decoder cannot take yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_buf <= ZERO_WORD;
        end else if (buffer_en) begin
            hold_buf <= inst_sram_rdata_i;
        end
    end

    // Decoder outputs: load on delivery, hold on stall, otherwise drop to a nop
    // while keeping the last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o       <= ZERO_WORD;
            inst_addr_o  <= ZERO_WORD;
            inst_valid_o <= FALSE_V;
        end else if (deliver) begin
            inst_o       <= deliver_word;
            inst_addr_o  <= pc;
            inst_valid_o <= TRUE_V;
        end else if (!stall_i) begin
            inst_o       <= ZERO_WORD;
            inst_valid_o <= FALSE_V;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small one-outstanding SRAM responder.
module tb_inst_fetch;

    localparam logic [31:0] KEY = 32'h1111_0000;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        br_e_i;
    logic [31:0] br_addr_i;
    logic        inst_sram_req_o;
    logic [31:0] inst_sram_addr_o;
    logic        inst_sram_gnt_i;
    logic        inst_sram_rvalid_i;
    logic [31:0] inst_sram_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    logic        gnt_en;
    logic        rv_block;
    logic        ovr_en;
    logic [31:0] ovr_data;
    logic        pend;
    logic [31:0] pend_addr;

    int n_cmp;
    int n_err;

    inst_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .br_e_i             (br_e_i),
        .br_addr_i          (br_addr_i),
        .inst_sram_req_o    (inst_sram_req_o),
        .inst_sram_addr_o   (inst_sram_addr_o),
        .inst_sram_gnt_i    (inst_sram_gnt_i),
        .inst_sram_rvalid_i (inst_sram_rvalid_i),
        .inst_sram_rdata_i  (inst_sram_rdata_i),
        .inst_o             (inst_o),
        .inst_addr_o        (inst_addr_o),
        .inst_valid_o       (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: grant combinationally, answer from the next cycle on
    // unless blocked; data is addr^KEY or an override word.
    assign inst_sram_gnt_i    = inst_sram_req_o & gnt_en;
    assign inst_sram_rvalid_i = pend & ~rv_block;
    assign inst_sram_rdata_i  = inst_sram_rvalid_i ? (ovr_en ? ovr_data : (pend_addr ^ KEY)) : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            if (inst_sram_rvalid_i) pend <= 1'b0;
            if (inst_sram_gnt_i) begin
                pend      <= 1'b1;
                pend_addr <= inst_sram_addr_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        stall_i   = 1'b0;
        br_e_i    = 1'b0;
        br_addr_i = 32'h0;
        gnt_en    = 1'b1;
        rv_block  = 1'b0;
        ovr_en    = 1'b0;
        ovr_data  = 32'h0;
        repeat (3) tick();

        chk("rst_req",   {31'b0, inst_sram_req_o}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst",  inst_o, 32'h0);
        chk("rst_iaddr", inst_addr_o, 32'h0);

        rst = 1'b0;
        chk("idle_req", {31'b0, inst_sram_req_o}, 32'd0);
        tick();
        chk("req0",      {31'b0, inst_sram_req_o}, 32'd1);
        chk("req0_addr", inst_sram_addr_o, 32'hBFC0_0000);
        tick();
        chk("wait0_req",   {31'b0, inst_sram_req_o}, 32'd0);
        chk("wait0_valid", {31'b0, inst_valid_o}, 32'd0);
        tick();
        chk("dlv0_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("dlv0_inst",  inst_o, 32'hAED1_0000);
        chk("dlv0_iaddr", inst_addr_o, 32'hBFC0_0000);
        chk("req1",       {31'b0, inst_sram_req_o}, 32'd1);
        chk("req1_addr",  inst_sram_addr_o, 32'hBFC0_0004);
        tick();
        chk("gap_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("gap_inst",  inst_o, 32'h0);
        chk("gap_iaddr", inst_addr_o, 32'hBFC0_0000);
        tick();
        chk("dlv1_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("dlv1_inst",  inst_o, 32'hAED1_0004);
        chk("dlv1_iaddr", inst_addr_o, 32'hBFC0_0004);
        chk("req2_addr",  inst_sram_addr_o, 32'hBFC0_0008);

        // stall while the next word returns
        stall_i  = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'h2402_0005;
        tick();
        chk("stall1_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("stall1_inst",  inst_o, 32'hAED1_0004);
        tick();
        chk("hold_req",   {31'b0, inst_sram_req_o}, 32'd0);
        chk("hold_inst",  inst_o, 32'hAED1_0004);
        chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
        tick();
        chk("hold2_req",  {31'b0, inst_sram_req_o}, 32'd0);
        chk("hold2_inst", inst_o, 32'hAED1_0004);
        stall_i = 1'b0;
        ovr_en  = 1'b0;
        tick();
        chk("unhold_inst",  inst_o, 32'h2402_0005);
        chk("unhold_iaddr", inst_addr_o, 32'hBFC0_0008);
        chk("unhold_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("req3_addr",    inst_sram_addr_o, 32'hBFC0_000C);

        // branch at BFC00010 to 80000100
        repeat (4) tick();
        chk("br_iaddr", inst_addr_o, 32'hBFC0_0010);
        chk("br_inst",  inst_o, 32'hAED1_0010);
        chk("ds_addr",  inst_sram_addr_o, 32'hBFC0_0014);
        br_e_i    = 1'b1;
        br_addr_i = 32'h8000_0100;
        tick();
        br_e_i = 1'b0;
        tick();
        chk("ds_iaddr",  inst_addr_o, 32'hBFC0_0014);
        chk("ds_valid",  {31'b0, inst_valid_o}, 32'd1);
        chk("tgt_addr",  inst_sram_addr_o, 32'h8000_0100);
        chk("tgt_req",   {31'b0, inst_sram_req_o}, 32'd1);
        repeat (2) tick();
        chk("tgt_iaddr", inst_addr_o, 32'h8000_0100);
        chk("tgt_inst",  inst_o, 32'h9111_0100);
        chk("tgt4_addr", inst_sram_addr_o, 32'h8000_0104);

        // branch coincident with the delay slot's rvalid
        stall_i  = 1'b1;
        rv_block = 1'b1;
        repeat (2) tick();
        chk("co_hold_iaddr", inst_addr_o, 32'h8000_0100);
        chk("co_hold_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("co_wait_req",   {31'b0, inst_sram_req_o}, 32'd0);
        stall_i   = 1'b0;
        rv_block  = 1'b0;
        br_e_i    = 1'b1;
        br_addr_i = 32'h8000_0200;
        tick();
        br_e_i = 1'b0;
        chk("co_ds_iaddr", inst_addr_o, 32'h8000_0104);
        chk("co_ds_inst",  inst_o, 32'h9111_0104);
        chk("co_tgt_addr", inst_sram_addr_o, 32'h8000_0200);
        repeat (2) tick();
        chk("co_tgt_iaddr", inst_addr_o, 32'h8000_0200);
        chk("co_next_addr", inst_sram_addr_o, 32'h8000_0204);

        // branch held four cycles under stall
        br_e_i    = 1'b1;
        br_addr_i = 32'h8000_0300;
        stall_i   = 1'b1;
        repeat (4) tick();
        chk("bh_iaddr", inst_addr_o, 32'h8000_0200);
        chk("bh_req",   {31'b0, inst_sram_req_o}, 32'd0);
        stall_i = 1'b0;
        br_e_i  = 1'b0;
        tick();
        chk("bh_ds_iaddr", inst_addr_o, 32'h8000_0204);
        chk("bh_ds_inst",  inst_o, 32'h9111_0204);
        chk("bh_tgt_addr", inst_sram_addr_o, 32'h8000_0300);
        repeat (2) tick();
        chk("bh_tgt_iaddr", inst_addr_o, 32'h8000_0300);
        chk("bh_next_addr", inst_sram_addr_o, 32'h8000_0304);

        // grant withheld for five cycles
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ng_addr",  inst_sram_addr_o, 32'h8000_0304);
            chk("ng_valid", {31'b0, inst_valid_o}, 32'd0);
            chk("ng_req",   {31'b0, inst_sram_req_o}, 32'd1);
        end
        gnt_en = 1'b1;
        tick();
        chk("pre_rst_wait", {31'b0, inst_sram_req_o}, 32'd0);

        // reset while a request is outstanding
        rst = 1'b1;
        tick();
        chk("wrst_req",   {31'b0, inst_sram_req_o}, 32'd0);
        chk("wrst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("wrst_inst",  inst_o, 32'h0);
        chk("wrst_iaddr", inst_addr_o, 32'h0);
        rst = 1'b0;
        tick();
        chk("restart_req",  {31'b0, inst_sram_req_o}, 32'd1);
        chk("restart_addr", inst_sram_addr_o, 32'hBFC0_0000);
        repeat (2) tick();
        chk("restart_iaddr", inst_addr_o, 32'hBFC0_0000);

        // PC wrap from FFFFFFFC to 0
        br_e_i    = 1'b1;
        br_addr_i = 32'hFFFF_FFFC;
        tick();
        br_e_i = 1'b0;
        tick();
        chk("wrap_tgt_addr", inst_sram_addr_o, 32'hFFFF_FFFC);
        repeat (2) tick();
        chk("wrap_iaddr", inst_addr_o, 32'hFFFF_FFFC);
        chk("wrap_inst",  inst_o, 32'hEEEE_FFFC);
        chk("wrap_addr",  inst_sram_addr_o, 32'h0000_0000);
        repeat (2) tick();
        chk("wrap0_iaddr", inst_addr_o, 32'h0000_0000);
        chk("wrap0_inst",  inst_o, 32'h1111_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
